// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: FSM states, register map, status bit positions
// and frame parity.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RTS,
        DATA,
        ACK,
        WAIT_IDLE
    } state_t;

    localparam logic R_STATUS = 1'b0;
    localparam logic R_DATA   = 1'b1;

    localparam int BUSY    = 7;
    localparam int ERROR   = 6;
    localparam int DONE    = 5;
    localparam int TIMEOUT = 4;

    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for the PS/2 clock and data lines, plus a one-cycle
// falling-edge pulse on the synchronized clock. Shared with the receiver.
module ps2_line_sync (
    input  logic clk,
    input  logic reset,
    input  logic clk_in,
    input  logic data_in,
    output logic clk_sync,
    output logic data_sync,
    output logic clk_fall
);

    logic [1:0] clk_ff;
    logic [1:0] data_ff;
    logic       clk_prev;

    // Lines idle high, so reset to 1 to avoid a false edge after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_ff   <= 2'b11;
            data_ff  <= 2'b11;
            clk_prev <= 1'b1;
        end else begin
            clk_ff   <= {clk_ff[0], clk_in};
            data_ff  <= {data_ff[0], data_in};
            clk_prev <= clk_ff[1];
        end
    end

    assign clk_sync  = clk_ff[1];
    assign data_sync = data_ff[1];
    assign clk_fall  = clk_prev & ~clk_ff[1];

endmodule

// File: rtl/ps2_tx.sv
// Host-to-device PS/2 transmitter on the 6502 bus (0x6000-0x7FFF, rs = a0).
// Build option PS2_TX_IRQ_EN: sys_irq follows ~done; otherwise sys_irq is tied high.
//
// state     | meaning
// IDLE      | lines released, waiting for a DATA write
// INHIBIT   | clock held low for INHIBIT_CYCLES
// RTS       | clock released, start bit on data, waiting for first device clock
// DATA      | data, parity and stop bits changed on device falling edges 1..10
// ACK       | waiting for falling edge 11 to sample the device acknowledge
// WAIT_IDLE | waiting for the device to release both lines
module ps2_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ps2_clk_in,
    input  logic        ps2_data_in,
    output logic        ps2_clk_oe,
    output logic        ps2_data_oe,
    input  logic [15:0] sys_adr,
    input  logic        sys_we,
    input  logic [7:0]  sys_data_in,
    output logic [7:0]  sys_data_out,
    output logic        sys_irq,
    output logic        tx_active
);

    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [INH_W-1:0] INH_LOAD = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LOAD  = TO_W'(TIMEOUT_CYCLES);

    logic clk_sync, data_sync, clk_fall;

    ps2_line_sync u_sync (
        .clk      (clk),
        .reset    (reset),
        .clk_in   (ps2_clk_in),
        .data_in  (ps2_data_in),
        .clk_sync (clk_sync),
        .data_sync(data_sync),
        .clk_fall (clk_fall)
    );

    state_t            state;
    logic              busy, error, done, timeout;
    logic [7:0]        tx_byte;
    logic [INH_W-1:0]  inh_cnt;
    logic [TO_W-1:0]   to_cnt;
    logic [3:0]        bit_cnt;
    logic              wr_q_d, rd_q_d;
    logic              sel, wr_q, rd_q, wr_pulse, rd_end;
    logic [7:0]        status, rdata;
    logic              unused_adr;

    assign sel        = ~sys_adr[15] & sys_adr[14] & sys_adr[13];
    assign wr_q       = sel & sys_we & (sys_adr[0] == R_DATA);
    assign rd_q       = sel & ~sys_we & (sys_adr[0] == R_STATUS);
    assign wr_pulse   = wr_q & ~wr_q_d;
    assign rd_end     = rd_q_d & ~rd_q;
    assign unused_adr = ^sys_adr[12:1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            busy        <= 1'b0;
            error       <= 1'b0;
            done        <= 1'b0;
            timeout     <= 1'b0;
            tx_byte     <= 8'h00;
            inh_cnt     <= '0;
            to_cnt      <= '0;
            bit_cnt     <= 4'd0;
            wr_q_d      <= 1'b0;
            rd_q_d      <= 1'b0;
        end else begin
            wr_q_d <= wr_q;
            rd_q_d <= rd_q;
            if (rd_end) begin
                done    <= 1'b0;
                error   <= 1'b0;
                timeout <= 1'b0;
            end
            // Timeout covers everything from RTS to the lines going idle.
            if (state != IDLE && state != INHIBIT && to_cnt == '0) begin
                state       <= IDLE;
                ps2_clk_oe  <= 1'b0;
                ps2_data_oe <= 1'b0;
                busy        <= 1'b0;
                error       <= 1'b1;
                timeout     <= 1'b1;
                done        <= 1'b1;
            end else begin
                if (state != IDLE && state != INHIBIT)
                    to_cnt <= to_cnt - 1'b1;
                case (state)
                    IDLE: begin
                        if (wr_pulse) begin
                            tx_byte     <= sys_data_in;
                            busy        <= 1'b1;
                            error       <= 1'b0;
                            done        <= 1'b0;
                            timeout     <= 1'b0;
                            inh_cnt     <= INH_LOAD;
                            bit_cnt     <= 4'd0;
                            ps2_clk_oe  <= 1'b1;
                            ps2_data_oe <= 1'b0;
                            state       <= INHIBIT;
                        end
                    end
                    INHIBIT: begin
                        if (inh_cnt == '0) begin
                            ps2_clk_oe  <= 1'b0;
                            ps2_data_oe <= 1'b1;
                            to_cnt      <= TO_LOAD;
                            state       <= RTS;
                        end else begin
                            inh_cnt <= inh_cnt - 1'b1;
                        end
                    end
                    RTS: begin
                        if (clk_fall) begin
                            bit_cnt     <= 4'd1;
                            ps2_data_oe <= ~tx_byte[0];
                            state       <= DATA;
                        end
                    end
                    DATA: begin
                        // bit_cnt holds the number of falling edges already seen.
                        if (clk_fall) begin
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt < 4'd8) begin
                                ps2_data_oe <= ~tx_byte[bit_cnt[2:0]];
                            end else if (bit_cnt == 4'd8) begin
                                ps2_data_oe <= ~odd_parity(tx_byte);
                            end else begin
                                ps2_data_oe <= 1'b0;
                                state       <= ACK;
                            end
                        end
                    end
                    ACK: begin
                        if (clk_fall) begin
                            if (data_sync)
                                error <= 1'b1;
                            state <= WAIT_IDLE;
                        end
                    end
                    WAIT_IDLE: begin
                        if (clk_sync && data_sync) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign tx_active = busy;

    always_comb begin
        status          = 8'h00;
        status[BUSY]    = busy;
        status[ERROR]   = error;
        status[DONE]    = done;
        status[TIMEOUT] = timeout;
    end

    assign rdata        = (sys_adr[0] == R_DATA) ? tx_byte : status;
    assign sys_data_out = (sel & ~sys_we) ? rdata : 8'hzz;

`ifdef PS2_TX_IRQ_EN
    logic irq_n;

    always_ff @(posedge clk) begin
        if (reset)
            irq_n <= 1'b1;
        else
            irq_n <= ~done;
    end

    assign sys_irq = irq_n;
`else
    assign sys_irq = 1'b1;
`endif

endmodule
